router_reg_gen: RTL and testbench

Parametrised successor of the router's register block. It captures the header, forwards payload bytes to the FIFO data bus, and parks a byte while the FIFO is full. It also keeps a running checksum (XOR parity or CRC, selectable) and checks the payload length against the header's length field. It sits between the router FSM (state strobes in) and the output FIFOs (`dout` out), and drives the FSM's `parity_done`/`low_pkt_valid` inputs.

---
 rtl/router_pkg.sv | 14 +
 rtl/router_chk_unit.sv | 31 +++
 rtl/router_reg_gen.sv | 134 +++++++++++++
 tb/tb_router_reg_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared constants and helpers for the router register block.
package router_pkg;

  localparam int unsigned CHK_XOR = 0;
  localparam int unsigned CHK_CRC = 1;

  localparam logic [7:0] DEFAULT_POLY = 8'h07;

  // Payload length lives above the destination address bits of the header.
  function automatic int unsigned len_field(input logic [31:0] hdr, input int unsigned addr_w);
    return int'(hdr >> addr_w);
  endfunction

endpackage

// File: rtl/router_chk_unit.sv
// One-byte checksum step: XOR parity or MSB-first CRC with an implicit top bit.
module router_chk_unit
  import router_pkg::*;
#(
  parameter int unsigned        DATA_W   = 8,
  parameter int unsigned        CHK_MODE = CHK_XOR,
  parameter logic [DATA_W-1:0]  POLY     = DATA_W'(DEFAULT_POLY)
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] acc_nxt
);

  logic              fb;
  logic [DATA_W-1:0] acc_w;

  always_comb begin
    fb    = 1'b0;
    acc_w = acc;
    if (CHK_MODE == CHK_CRC) begin
      for (int i = DATA_W - 1; i >= 0; i--) begin
        fb    = acc_w[DATA_W-1] ^ d[i];
        acc_w = (acc_w << 1) ^ (fb ? POLY : '0);
      end
    end else begin
      acc_w = acc ^ d;
    end
    acc_nxt = acc_w;
  end

endmodule

// File: rtl/router_reg_gen.sv
// Router register block: header capture, payload forwarding with a one-byte
// park register for FIFO-full, running checksum and length check.
module router_reg_gen
  import router_pkg::*;
#(
  parameter int unsigned        DATA_W   = 8,
  parameter int unsigned        ADDR_W   = 2,
  parameter int unsigned        CHK_MODE = CHK_XOR,
  parameter logic [DATA_W-1:0]  POLY     = DATA_W'(DEFAULT_POLY)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err,
  output logic              len_err
);

  localparam int unsigned LEN_W = DATA_W - ADDR_W;

  logic [DATA_W-1:0] header;
  logic [DATA_W-1:0] hold;
  logic              hold_v;
  logic [DATA_W-1:0] chk_acc;
  logic [DATA_W-1:0] pkt_chk;
  logic [LEN_W-1:0]  byte_cnt;
  logic              chk_arm;
  logic [DATA_W-1:0] chk_in;
  logic [DATA_W-1:0] chk_nxt;
  logic [LEN_W-1:0]  hdr_len;

  assign chk_in  = lfd_state ? header : data_in;
  assign hdr_len = LEN_W'(len_field(32'(header), ADDR_W));

  router_chk_unit #(
    .DATA_W   (DATA_W),
    .CHK_MODE (CHK_MODE),
    .POLY     (POLY)
  ) u_chk (
    .acc     (chk_acc),
    .d       (chk_in),
    .acc_nxt (chk_nxt)
  );

  // chk_arm keeps the comparison from re-evaluating against cleared state
  // after rst_int_reg, so a stale err survives until the next detect_add.
  always_ff @(posedge clock) begin
    if (reset) begin
      header        <= '0;
      hold          <= '0;
      hold_v        <= 1'b0;
      chk_acc       <= '0;
      pkt_chk       <= '0;
      byte_cnt      <= '0;
      chk_arm       <= 1'b0;
      dout          <= '0;
      parity_done   <= 1'b0;
      low_pkt_valid <= 1'b0;
      err           <= 1'b0;
      len_err       <= 1'b0;
    end else begin
      if (parity_done && chk_arm) begin
        err     <= (pkt_chk != chk_acc);
        len_err <= (byte_cnt != hdr_len);
      end

      if (rst_int_reg) begin
        header        <= '0;
        hold          <= '0;
        hold_v        <= 1'b0;
        chk_acc       <= '0;
        pkt_chk       <= '0;
        byte_cnt      <= '0;
        chk_arm       <= 1'b0;
        low_pkt_valid <= 1'b0;
      end else if (detect_add) begin
        if (pkt_valid) header <= data_in;
        chk_acc     <= '0;
        byte_cnt    <= '0;
        chk_arm     <= 1'b0;
        parity_done <= 1'b0;
        err         <= 1'b0;
        len_err     <= 1'b0;
      end else if (lfd_state) begin
        dout    <= header;
        chk_acc <= chk_nxt;
      end else if (ld_state) begin
        if (pkt_valid) begin
          chk_acc <= chk_nxt;
          if (byte_cnt != {LEN_W{1'b1}}) byte_cnt <= byte_cnt + 1'b1;
          if (!fifo_full) begin
            dout <= data_in;
          end else begin
            hold   <= data_in;
            hold_v <= 1'b1;
          end
        end else begin
          pkt_chk       <= data_in;
          low_pkt_valid <= 1'b1;
          if (!fifo_full) begin
            dout        <= data_in;
            parity_done <= 1'b1;
            chk_arm     <= 1'b1;
          end else begin
            hold   <= data_in;
            hold_v <= 1'b1;
          end
        end
      end else if (laf_state) begin
        if (hold_v) begin
          dout   <= hold;
          hold_v <= 1'b0;
        end
        if (!pkt_valid && !parity_done) begin
          parity_done <= 1'b1;
          chk_arm     <= 1'b1;
        end
      end else if (full_state) begin
        // hold and everything else are retained while the FIFO drains
      end
    end
  end

endmodule

// File: tb/tb_router_reg_gen.sv
// Directed bench: one XOR-mode and one CRC-mode instance driven in parallel.
module tb_router_reg_gen;

  localparam int S_NONE = 0, S_DA = 1, S_LFD = 2, S_LD = 3, S_LAF = 4,
                 S_FULL = 5, S_RINT = 6, S_RST = 7;

  logic       clock = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;

  logic [7:0] dout_x, dout_c;
  logic       pd_x, pd_c, lpv_x, lpv_c, err_x, err_c, lerr_x, lerr_c;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  router_reg_gen #(.DATA_W(8), .ADDR_W(2), .CHK_MODE(0), .POLY(8'h07)) u_xor (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .dout(dout_x), .parity_done(pd_x),
    .low_pkt_valid(lpv_x), .err(err_x), .len_err(lerr_x)
  );

  router_reg_gen #(.DATA_W(8), .ADDR_W(2), .CHK_MODE(1), .POLY(8'h07)) u_crc (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .dout(dout_c), .parity_done(pd_c),
    .low_pkt_valid(lpv_c), .err(err_c), .len_err(lerr_c)
  );

  task automatic step(input int st, input logic pv, input logic [7:0] d, input logic full);
    {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = '0;
    reset = 1'b0;
    case (st)
      S_DA:    detect_add  = 1'b1;
      S_LFD:   lfd_state   = 1'b1;
      S_LD:    ld_state    = 1'b1;
      S_LAF:   laf_state   = 1'b1;
      S_FULL:  full_state  = 1'b1;
      S_RINT:  rst_int_reg = 1'b1;
      S_RST:   reset       = 1'b1;
      default: ;
    endcase
    pkt_valid = pv;
    data_in   = d;
    fifo_full = full;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    step(S_RST, 1'b0, 8'h00, 1'b0);
    step(S_RST, 1'b0, 8'h00, 1'b0);
    total++;
    if ({dout_x, pd_x, lpv_x, err_x, lerr_x} !== 12'h000) begin
      bad++; $display("FAIL reset_xor got=%h exp=000", {dout_x, pd_x, lpv_x, err_x, lerr_x});
    end
    total++;
    if ({dout_c, pd_c, lpv_c, err_c, lerr_c} !== 12'h000) begin
      bad++; $display("FAIL reset_crc got=%h exp=000", {dout_c, pd_c, lpv_c, err_c, lerr_c});
    end
  endtask

  // Header 0x05, payload 0xA5, checksum byte supplied by caller.
  task automatic test_basic(input logic [7:0] chk, input logic exp_ex, input logic exp_ec);
    step(S_DA, 1'b1, 8'h05, 1'b0);
    step(S_LFD, 1'b1, 8'h00, 1'b0);
    total++;
    if (dout_x !== 8'h05) begin bad++; $display("FAIL basic_hdr_dout got=%h exp=05", dout_x); end
    step(S_LD, 1'b1, 8'hA5, 1'b0);
    total++;
    if (dout_x !== 8'hA5) begin bad++; $display("FAIL basic_pay_dout got=%h exp=a5", dout_x); end
    step(S_LD, 1'b0, chk, 1'b0);
    total++;
    if (dout_x !== chk) begin bad++; $display("FAIL basic_chk_dout got=%h exp=%h", dout_x, chk); end
    total++;
    if ({pd_x, lpv_x, pd_c} !== 3'b111) begin
      bad++; $display("FAIL basic_pd_lpv got=%b exp=111", {pd_x, lpv_x, pd_c});
    end
    total++;
    if (err_c !== 1'b0) begin bad++; $display("FAIL basic_err_early got=%b exp=0", err_c); end
    step(S_NONE, 1'b0, 8'h00, 1'b0);
    total++;
    if (err_x !== exp_ex) begin bad++; $display("FAIL basic_err_xor got=%b exp=%b", err_x, exp_ex); end
    total++;
    if (err_c !== exp_ec) begin bad++; $display("FAIL basic_err_crc got=%b exp=%b", err_c, exp_ec); end
    total++;
    if ({lerr_x, lerr_c} !== 2'b00) begin
      bad++; $display("FAIL basic_len_err got=%b exp=00", {lerr_x, lerr_c});
    end
  endtask

  task automatic test_rst_int();
    step(S_RINT, 1'b0, 8'h00, 1'b0);
    step(S_NONE, 1'b0, 8'h00, 1'b0);
    total++;
    if ({lpv_x, lpv_c} !== 2'b00) begin
      bad++; $display("FAIL rint_lpv got=%b exp=00", {lpv_x, lpv_c});
    end
    total++;
    if (dout_c !== 8'hA0) begin bad++; $display("FAIL rint_dout got=%h exp=a0", dout_c); end
    total++;
    if ({pd_c, err_c} !== 2'b11) begin
      bad++; $display("FAIL rint_stale_err got=%b exp=11", {pd_c, err_c});
    end
  endtask

  task automatic test_len_mismatch();
    step(S_DA, 1'b1, 8'h09, 1'b0);
    step(S_LFD, 1'b1, 8'h00, 1'b0);
    step(S_LD, 1'b1, 8'h11, 1'b0);
    step(S_LD, 1'b0, 8'h18, 1'b0);
    step(S_NONE, 1'b0, 8'h00, 1'b0);
    total++;
    if ({err_x, lerr_x} !== 2'b01) begin
      bad++; $display("FAIL len_mismatch got=%b exp=01", {err_x, lerr_x});
    end
  endtask

  task automatic test_len_zero();
    step(S_DA, 1'b1, 8'h01, 1'b0);
    step(S_LFD, 1'b1, 8'h00, 1'b0);
    step(S_LD, 1'b0, 8'h01, 1'b0);
    step(S_NONE, 1'b0, 8'h00, 1'b0);
    total++;
    if ({pd_x, err_x, lerr_x} !== 3'b100) begin
      bad++; $display("FAIL len_zero got=%b exp=100", {pd_x, err_x, lerr_x});
    end
  endtask

  task automatic test_fifo_full_payload();
    step(S_DA, 1'b1, 8'h05, 1'b0);
    step(S_LFD, 1'b1, 8'h00, 1'b0);
    step(S_LD, 1'b1, 8'h3C, 1'b1);
    total++;
    if (dout_x !== 8'h05) begin bad++; $display("FAIL full_dout_held got=%h exp=05", dout_x); end
    for (int i = 0; i < 3; i++) step(S_FULL, 1'b1, 8'h00, 1'b1);
    total++;
    if (dout_x !== 8'h05) begin bad++; $display("FAIL full_state_dout got=%h exp=05", dout_x); end
    step(S_LAF, 1'b1, 8'h00, 1'b0);
    total++;
    if ({dout_x, pd_x} !== {8'h3C, 1'b0}) begin
      bad++; $display("FAIL full_drain got=%h/%b exp=3c/0", dout_x, pd_x);
    end
    step(S_LD, 1'b0, 8'h39, 1'b0);
    step(S_NONE, 1'b0, 8'h00, 1'b0);
    total++;
    if ({err_x, lerr_x} !== 2'b00) begin
      bad++; $display("FAIL full_once_xor got=%b exp=00", {err_x, lerr_x});
    end
    total++;
    if (err_c !== 1'b1) begin bad++; $display("FAIL full_once_crc got=%b exp=1", err_c); end
  endtask

  task automatic test_fifo_full_checksum();
    step(S_DA, 1'b1, 8'h05, 1'b0);
    step(S_LFD, 1'b1, 8'h00, 1'b0);
    step(S_LD, 1'b1, 8'hA5, 1'b0);
    step(S_LD, 1'b0, 8'hA0, 1'b1);
    total++;
    if ({dout_x, pd_x, lpv_x} !== {8'hA5, 2'b01}) begin
      bad++; $display("FAIL chkfull_park got=%h/%b/%b exp=a5/0/1", dout_x, pd_x, lpv_x);
    end
    step(S_FULL, 1'b0, 8'h00, 1'b1);
    total++;
    if (pd_x !== 1'b0) begin bad++; $display("FAIL chkfull_wait got=%b exp=0", pd_x); end
    step(S_LAF, 1'b0, 8'h00, 1'b0);
    total++;
    if ({dout_x, pd_x} !== {8'hA0, 1'b1}) begin
      bad++; $display("FAIL chkfull_drain got=%h/%b exp=a0/1", dout_x, pd_x);
    end
    step(S_NONE, 1'b0, 8'h00, 1'b0);
    total++;
    if ({err_x, lerr_x} !== 2'b00) begin
      bad++; $display("FAIL chkfull_err got=%b exp=00", {err_x, lerr_x});
    end
  endtask

  task automatic test_reset_mid();
    step(S_DA, 1'b1, 8'h05, 1'b0);
    step(S_LFD, 1'b1, 8'h00, 1'b0);
    step(S_LD, 1'b1, 8'hA5, 1'b0);
    step(S_RST, 1'b1, 8'h00, 1'b0);
    total++;
    if ({dout_x, pd_x, lpv_x, err_x, lerr_x, dout_c} !== 20'h0) begin
      bad++; $display("FAIL mid_reset got=%h exp=0", {dout_x, pd_x, lpv_x, err_x, lerr_x, dout_c});
    end
    test_basic(8'hA0, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    pkt_valid = 1'b0; data_in = '0; fifo_full = 1'b0;
    {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = '0;
    test_reset();
    test_basic(8'hA0, 1'b0, 1'b1);
    test_rst_int();
    test_basic(8'h33, 1'b1, 1'b0);
    test_len_mismatch();
    test_len_zero();
    test_fifo_full_payload();
    test_fifo_full_checksum();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
